// File: rtl/peridot_conf_host_encoder_pkg.sv
// Shared constants, state encodings and byte classifiers for the PERIDOT
// host-side configuration encoder.
package peridot_conf_host_encoder_pkg;

   localparam logic [7:0] CMD_BYTE        = 8'h3a;
   localparam logic [7:0] ESC_BYTE        = 8'h3d;
   localparam logic [7:0] ESC_XOR         = 8'h20;
   localparam logic [3:0] RESP_LOW_NIBBLE = 4'h7;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_CMD2 = 2'd1,
      TX_ESC2 = 2'd2
   } tx_state_t;

   typedef enum logic [1:0] {
      RIDLE  = 2'd0,
      RARMED = 2'd1,
      RWAIT  = 2'd2
   } resp_state_t;

   // Config response bytes look like {2'b00, sda, scl, 4'h7}.
   function automatic logic is_resp_byte(input logic [7:0] b);
      return (b[7:6] == 2'b00) && (b[3:0] == RESP_LOW_NIBBLE);
   endfunction

   // Raw bytes that collide with the command lead or the escape byte.
   function automatic logic needs_escape(input logic [7:0] b);
      return (b == CMD_BYTE) || (b == ESC_BYTE);
   endfunction

endpackage

// File: rtl/peridot_conf_resp_tracker.sv
// Response tracker: waits for the config response after a command,
// times out if none arrives, and filters the response byte out of the
// return stream while forwarding everything else to the host.
module peridot_conf_resp_tracker
   import peridot_conf_host_encoder_pkg::*;
#(
   parameter int RESP_TIMEOUT = 1024,
   parameter int TIMER_WIDTH  = 11
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       arm,
   input  logic       cmd2_accept,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_ready,
   input  logic       host_ready,
   output logic       host_valid,
   output logic [7:0] host_data,
   output logic       resp_idle,
   output logic       conf_busy,
   output logic       conf_done,
   output logic       conf_timeout,
   output logic       conf_resp_scl,
   output logic       conf_resp_sda
);

   resp_state_t            state;
   logic [TIMER_WIDTH-1:0] timer;
   logic                   match;
   logic                   expire;

   assign match     = (state == RWAIT) && rx_valid && is_resp_byte(rx_data);
   assign expire    = (state == RWAIT) && (timer == TIMER_WIDTH'(RESP_TIMEOUT - 1));
   assign resp_idle = (state == RIDLE);
   assign conf_busy = (state != RIDLE);

   // Return stream: the response byte is swallowed, all else passes through.
   always_comb begin
      rx_ready   = host_ready;
      host_valid = rx_valid;
      host_data  = rx_data;
      if (match) begin
         rx_ready   = 1'b1;
         host_valid = 1'b0;
      end
   end

   // Response FSM with timeout counter; a match beats a same-cycle timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= RIDLE;
         timer         <= '0;
         conf_done     <= 1'b0;
         conf_timeout  <= 1'b0;
         conf_resp_scl <= 1'b0;
         conf_resp_sda <= 1'b0;
      end else begin
         conf_done <= 1'b0;
         case (state)
            RIDLE: begin
               if (arm) state <= RARMED;
            end
            RARMED: begin
               if (cmd2_accept) begin
                  state <= RWAIT;
                  timer <= '0;
               end
            end
            RWAIT: begin
               timer <= timer + TIMER_WIDTH'(1);
               if (match) begin
                  conf_done     <= 1'b1;
                  conf_timeout  <= 1'b0;
                  conf_resp_sda <= rx_data[5];
                  conf_resp_scl <= rx_data[4];
                  state         <= RIDLE;
               end else if (expire) begin
                  conf_done     <= 1'b1;
                  conf_timeout  <= 1'b1;
                  conf_resp_sda <= 1'b0;
                  conf_resp_scl <= 1'b0;
                  state         <= RIDLE;
               end
            end
            default: state <= RIDLE;
         endcase
      end
   end

endmodule

// File: rtl/peridot_conf_host_encoder.sv
// Host-side PERIDOT configuration encoder: escapes and frames the raw byte
// stream plus config commands, and extracts config responses on return.
module peridot_conf_host_encoder
   import peridot_conf_host_encoder_pkg::*;
#(
   parameter int RESP_TIMEOUT = 1024,
   parameter int TIMER_WIDTH  = 11
) (
   input  logic       clk,
   input  logic       reset,
   output logic       in_ready,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   input  logic       conf_req,
   input  logic       conf_scl,
   input  logic       conf_sda,
   output logic       conf_ack,
   output logic       conf_busy,
   output logic       conf_done,
   output logic       conf_timeout,
   output logic       conf_resp_scl,
   output logic       conf_resp_sda,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       rx_ready,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       host_ready,
   output logic       host_valid,
   output logic [7:0] host_data
);

   tx_state_t  tx_state;
   logic       slot_free;
   logic       resp_idle;
   logic       cmd_grant;
   logic       cmd2_accept;
   logic       out_is_cmd2;
   logic       latch_scl;
   logic       latch_sda;
   logic [7:0] esc_saved;

   assign slot_free   = !out_valid || out_ready;
   assign cmd_grant   = (tx_state == TX_IDLE) && slot_free && resp_idle && conf_req;
   assign in_ready    = (tx_state == TX_IDLE) && slot_free && !(conf_req && resp_idle);
   // The response window opens only once the second command byte is taken.
   assign cmd2_accept = out_valid && out_ready && out_is_cmd2;

   // Transmit encoder: one output register, commands preferred over data.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state    <= TX_IDLE;
         out_valid   <= 1'b0;
         out_data    <= 8'h00;
         out_is_cmd2 <= 1'b0;
         conf_ack    <= 1'b0;
         latch_scl   <= 1'b0;
         latch_sda   <= 1'b0;
         esc_saved   <= 8'h00;
      end else begin
         conf_ack <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid   <= 1'b0;
            out_is_cmd2 <= 1'b0;
         end
         case (tx_state)
            TX_IDLE: begin
               if (cmd_grant) begin
                  out_valid   <= 1'b1;
                  out_data    <= CMD_BYTE;
                  out_is_cmd2 <= 1'b0;
                  latch_scl   <= conf_scl;
                  latch_sda   <= conf_sda;
                  conf_ack    <= 1'b1;
                  tx_state    <= TX_CMD2;
               end else if (in_valid && in_ready) begin
                  out_valid   <= 1'b1;
                  out_is_cmd2 <= 1'b0;
                  if (needs_escape(in_data)) begin
                     out_data  <= ESC_BYTE;
                     esc_saved <= in_data ^ ESC_XOR;
                     tx_state  <= TX_ESC2;
                  end else begin
                     out_data <= in_data;
                  end
               end
            end
            TX_CMD2: begin
               if (slot_free) begin
                  out_valid   <= 1'b1;
                  out_data    <= {2'b00, latch_sda, latch_scl, 4'h0};
                  out_is_cmd2 <= 1'b1;
                  tx_state    <= TX_IDLE;
               end
            end
            TX_ESC2: begin
               if (slot_free) begin
                  out_valid   <= 1'b1;
                  out_data    <= esc_saved;
                  out_is_cmd2 <= 1'b0;
                  tx_state    <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   peridot_conf_resp_tracker #(
      .RESP_TIMEOUT (RESP_TIMEOUT),
      .TIMER_WIDTH  (TIMER_WIDTH)
   ) u_resp_tracker (
      .clk           (clk),
      .reset         (reset),
      .arm           (cmd_grant),
      .cmd2_accept   (cmd2_accept),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .rx_ready      (rx_ready),
      .host_ready    (host_ready),
      .host_valid    (host_valid),
      .host_data     (host_data),
      .resp_idle     (resp_idle),
      .conf_busy     (conf_busy),
      .conf_done     (conf_done),
      .conf_timeout  (conf_timeout),
      .conf_resp_scl (conf_resp_scl),
      .conf_resp_sda (conf_resp_sda)
   );

endmodule

// File: tb/tb_peridot_conf_host_encoder.sv
// Scoreboard bench for peridot_conf_host_encoder.
module tb_peridot_conf_host_encoder;

   localparam int RT = 16;
   localparam int TW = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_ready;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       conf_req = 1'b0;
   logic       conf_scl = 1'b0;
   logic       conf_sda = 1'b0;
   logic       conf_ack;
   logic       conf_busy;
   logic       conf_done;
   logic       conf_timeout;
   logic       conf_resp_scl;
   logic       conf_resp_sda;
   logic       out_ready = 1'b1;
   logic       out_valid;
   logic [7:0] out_data;
   logic       rx_ready;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       host_ready = 1'b1;
   logic       host_valid;
   logic [7:0] host_data;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   logic       toggle_rdy = 1'b0;
   logic       stall_prev = 1'b0;
   logic [7:0] data_prev = 8'h00;
   logic [7:0] exp_byte;

   peridot_conf_host_encoder #(
      .RESP_TIMEOUT (RT),
      .TIMER_WIDTH  (TW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_ready      (in_ready),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .conf_req      (conf_req),
      .conf_scl      (conf_scl),
      .conf_sda      (conf_sda),
      .conf_ack      (conf_ack),
      .conf_busy     (conf_busy),
      .conf_done     (conf_done),
      .conf_timeout  (conf_timeout),
      .conf_resp_scl (conf_resp_scl),
      .conf_resp_sda (conf_resp_sda),
      .out_ready     (out_ready),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .rx_ready      (rx_ready),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .host_ready    (host_ready),
      .host_valid    (host_valid),
      .host_data     (host_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on each handshake, checks hold on stalls.
   always @(negedge clk) begin
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, data_prev);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("out_unexpected", out_data, 32'h100);
            end else begin
               exp_byte = exp_q.pop_front();
               check("out_byte", out_data, exp_byte);
            end
         end
         stall_prev = out_valid && !out_ready;
         data_prev  = out_data;
      end
   end

   // Optional out_ready toggling for backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (toggle_rdy) out_ready = ~out_ready;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         if (b == 8'h3a || b == 8'h3d) begin
            exp_q.push_back(8'h3d);
            exp_q.push_back(b ^ 8'h20);
         end else begin
            exp_q.push_back(b);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         if (b == 8'h3a || b == 8'h3d) begin
            @(negedge clk);
            check("esc2_in_ready", in_ready, 0);
         end
      end
   endtask

   task automatic do_conf(input logic scl, input logic sda);
      int   n;
      logic got;
      n = 0;
      got = 1'b0;
      conf_scl = scl;
      conf_sda = sda;
      conf_req = 1'b1;
      while (!got && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (conf_ack) got = 1'b1;
      end
      conf_req = 1'b0;
      check("conf_ack_seen", got, 1);
      if (got) begin
         exp_q.push_back(8'h3a);
         exp_q.push_back({2'b00, sda, scl, 4'h0});
         check("conf_busy_at_ack", conf_busy, 1);
         tick(1);
         check("conf_ack_pulse", conf_ack, 0);
      end
   endtask

   task automatic wait_done(output int cycles);
      int n;
      n = 0;
      while (!conf_done && n < 4 * RT) begin
         tick(1);
         n++;
      end
      check("conf_done_seen", conf_done, 1);
      cycles = n;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick(1);
         n++;
      end
      check("sb_drain", exp_q.size(), 0);
   endtask

   initial begin
      int cyc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_conf_busy", conf_busy, 0);
      check("rst_conf_ack", conf_ack, 0);
      check("rst_conf_done", conf_done, 0);
      check("rst_conf_timeout", conf_timeout, 0);
      check("rst_in_ready", in_ready, 1);

      // Data path with escaping
      send_byte(8'h41);
      send_byte(8'h3a);
      send_byte(8'h3d);
      send_byte(8'h5d);
      drain();

      // Config command with a matching response
      do_conf(1'b1, 1'b0);
      tick(2);
      rx_valid = 1'b1;
      rx_data  = 8'h17;
      @(negedge clk);
      check("resp_not_forwarded", host_valid, 0);
      check("resp_rx_ready", rx_ready, 1);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      check("resp_done", conf_done, 1);
      check("resp_scl", conf_resp_scl, 1);
      check("resp_sda", conf_resp_sda, 0);
      check("resp_timeout", conf_timeout, 0);
      check("resp_busy_clear", conf_busy, 0);
      tick(1);
      check("resp_done_pulse", conf_done, 0);
      check("resp_scl_held", conf_resp_scl, 1);
      drain();

      // Timeout measured from the second command byte handshake
      do_conf(1'b1, 1'b1);
      wait_done(cyc);
      check("timeout_latency", cyc, RT + 1);
      check("timeout_flag", conf_timeout, 1);
      check("timeout_scl", conf_resp_scl, 0);
      check("timeout_sda", conf_resp_sda, 0);
      tick(1);
      check("timeout_busy_clear", conf_busy, 0);
      drain();

      // Filter: non-response forwarded, response captured, then passthrough
      do_conf(1'b0, 1'b0);
      tick(2);
      host_ready = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h55;
      @(negedge clk);
      check("flt_fwd_valid", host_valid, 1);
      check("flt_fwd_data", host_data, 8'h55);
      check("flt_fwd_ready", rx_ready, 1);
      @(posedge clk);
      #1;
      check("flt_no_done", conf_done, 0);
      rx_data = 8'h37;
      @(negedge clk);
      check("flt_cap_hidden", host_valid, 0);
      @(posedge clk);
      #1;
      check("flt_cap_done", conf_done, 1);
      check("flt_cap_sda", conf_resp_sda, 1);
      check("flt_cap_scl", conf_resp_scl, 1);
      check("flt_cap_timeout", conf_timeout, 0);
      host_ready = 1'b0;
      @(negedge clk);
      check("flt_idle_fwd_valid", host_valid, 1);
      check("flt_idle_fwd_data", host_data, 8'h37);
      check("flt_idle_rx_ready", rx_ready, 0);
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      host_ready = 1'b1;
      drain();

      // Priority and backpressure
      toggle_rdy = 1'b1;
      fork
         do_conf(1'b0, 1'b1);
         send_byte(8'h3a);
      join
      drain();
      toggle_rdy = 1'b0;
      out_ready = 1'b1;
      wait_done(cyc);
      check("prio_timeout_flag", conf_timeout, 1);
      tick(2);

      // Reset in the middle of an escaped pair
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h3a;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("mid_esc_valid", out_valid, 1);
      check("mid_esc_data", out_data, 8'h3d);
      check("mid_esc_in_ready", in_ready, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("post_rst_valid", out_valid, 0);
      check("post_rst_busy", conf_busy, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         check("post_rst_no_stray", out_valid, 0);
      end
      check("final_sb_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/peridot_conf_host_encoder.md
Name: peridot_conf_host_encoder

Overview:
Host-side counterpart of the PERIDOT configuration layer.
- Upstream direction: turns a raw byte stream plus configuration-command requests into the escaped, framed stream the configuration layer parses. 0x3a is the command lead byte and 0x3d is the escape byte.
- Return direction: extracts the config response byte, of the form {2'b00, sda, scl, 4'h7}, and forwards all other bytes.
- Sits between the host bridge (USB/UART FIFO) and the channel feeding the board's configuration layer; used to bit-bang the board serial EEPROM over I2C.

Parameters:
RESP_TIMEOUT, 1024, cycles to wait for a response after the command's 2nd byte is accepted; must be >= 2.
TIMER_WIDTH, 11, width of the timeout counter; must hold RESP_TIMEOUT.

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high
in_ready  out  1  data byte accepted when in_valid && in_ready
in_valid  in  1  raw data byte valid
in_data  in  8  raw data byte
conf_req  in  1  request a config command; held until conf_ack
conf_scl  in  1  SCL level to send
conf_sda  in  1  SDA level to send
conf_ack  out  1  1-cycle pulse: request latched
conf_busy  out  1  high from latch until response or timeout
conf_done  out  1  1-cycle pulse: command completed
conf_timeout  out  1  qualifies conf_done: no response received
conf_resp_scl  out  1  SCL from response, valid at conf_done
conf_resp_sda  out  1  SDA from response, valid at conf_done
out_ready  in  1  downstream accepts out_data
out_valid  out  1  encoded byte valid
out_data  out  8  encoded byte
rx_ready  out  1  return-stream ready
rx_valid  in  1  return byte valid
rx_data  in  8  return byte
host_ready  in  1  host accepts forwarded byte
host_valid  out  1  forwarded return byte valid
host_data  out  8  forwarded return byte

Behaviour:
- Clock and reset: one clock, `clk`. `reset` is synchronous and active-high; it is sampled on the rising edge of `clk`.
- Reset values: all outputs 0, out_data = 8'h00, tx state IDLE, resp state RIDLE, timer = 0.
- Output register:
  - out_valid/out_data are registered and held stable until out_valid && out_ready.
  - "Slot free" = !out_valid || out_ready.
- Transmit FSM:
  - IDLE, slot free, resp state RIDLE, conf_req=1: load out_data=8'h3a; latch scl/sda; pulse conf_ack; go to CMD2. Config has priority over data.
  - IDLE, slot free, otherwise, in_valid=1 with in_data = 0x3a or 0x3d: load 8'h3d; save in_data^8'h20; go to ESC2.
  - IDLE, slot free, otherwise, other in_valid byte: load it directly; stay in IDLE.
  - CMD2, slot free: load {2'b00, sda, scl, 4'h0}; go to IDLE; arm response wait on acceptance of this byte.
  - ESC2, slot free: load saved byte; go to IDLE.
- in_ready: = (state==IDLE) && slot free && !(conf_req && resp RIDLE). Combinational from registered state.
- Latency: a byte accepted at cycle N appears on out_valid at N+1. An escaped pair occupies 2 consecutive output slots. Bubbles occur only when out_ready=0.
- Response FSM:
  - RIDLE → ARMED when conf_ack pulses; conf_busy=1.
  - ARMED → WAIT when the CMD2 byte handshakes; timer cleared.
  - WAIT: timer increments each cycle.
    - Byte matching (rx_data[7:6]==2'b00 && rx_data[3:0]==4'h7) with rx_valid: consumed and not forwarded. Pulse conf_done; resp_sda=rx_data[5], resp_scl=rx_data[4]; conf_timeout=0; go to RIDLE.
    - timer==RESP_TIMEOUT-1 with no match: pulse conf_done with conf_timeout=1; resp bits 0; go to RIDLE.
    - Match and timeout in the same cycle: the match wins.
  - conf_busy = (resp state != RIDLE). New conf_req is blocked until RIDLE.
- Return passthrough:
  - Non-matching bytes, and all bytes outside WAIT, are forwarded combinationally: host_valid=rx_valid, host_data=rx_data, rx_ready=host_ready.
  - During WAIT, a matching byte gives rx_ready=1 and host_valid=0.
- conf_resp_* and conf_timeout hold their values until the next conf_done.
- Mid-operation reset: an in-flight escaped pair or command pair is dropped; no partial second byte is emitted after reset.

Decomposition:
- Shared package: constants CMD_BYTE=8'h3a, ESC_BYTE=8'h3d, ESC_XOR=8'h20, RESP_LOW_NIBBLE=4'h7; enums for the tx and resp states.
- One sub-module: peridot_conf_resp_tracker (response FSM, timer and return-stream filter).
- The tx encoder stays in the top module.

Test Plan:
- Data path: in bytes 0x41, 0x3a, 0x3d, 0x5d with out_ready=1 → out 0x41, 0x3d, 0x1a, 0x3d, 0x1d, 0x5d; in_ready low during each ESC2 cycle.
- Config command: conf_req with scl=1, sda=0 → out 0x3a, 0x10; conf_ack one cycle. Then rx 0x17 → conf_done, resp_scl=1, resp_sda=0, conf_timeout=0; 0x17 not seen on host.
- Timeout: config command with no rx traffic → conf_done + conf_timeout exactly RESP_TIMEOUT cycles after the CMD2 handshake. A following conf_req is accepted.
- Priority/backpressure: conf_req and in_valid=0x3a same cycle, out_ready toggling 1/0 → out 0x3a, (cmd byte), then 0x3d, 0x1a; every byte held stable while out_ready=0.
- Filter: during WAIT rx 0x55, 0x37 with host_ready=1 → 0x55 forwarded, 0x37 captured (sda=1, scl=1). Outside WAIT, 0x37 is forwarded.
- Reset mid-ESC2 → out_valid=0 the cycle after reset; no stray 0x1a; conf_busy=0.
